// File: rtl/snake_step.sv
// Snake movement engine: keeps the body in an external circular RAM buffer,
// tracks cell occupancy, detects self-collision and issues erase/draw plots.
module snake_step (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [1:0] dir,
    input  logic       grow,
    output logic       waitrequest,
    output logic       collision,
    output logic [7:0] length,
    output logic       ram_we,
    output logic [7:0] ram_wr_addr,
    output logic [7:0] ram_wr_data,
    output logic [7:0] ram_rd_addr,
    input  logic [7:0] ram_rd_data,
    output logic       game_plot,
    output logic [3:0] game_x,
    output logic [3:0] game_y,
    output logic [2:0] game_colour,
    input  logic       plot_waitrequest
);

    typedef enum logic [2:0] {
        INIT, IDLE, RD_TAIL, CHECK, ERASE, WRITE, DRAW, DEAD
    } state_t;

    state_t       state;
    logic [7:0]   head;
    logic [7:0]   new_head;
    logic [7:0]   tail_xy;
    logic [7:0]   head_ptr;
    logic [7:0]   tail_ptr;
    logic [1:0]   cur_dir;
    logic [1:0]   dir_eff;
    logic         grow_eff;
    logic [255:0] occ;

    logic [1:0]   dir_sel;
    logic [3:0]   hx;
    logic [3:0]   hy;
    logic [7:0]   next_cell;
    logic         hit;

    always_comb begin
        dir_sel = dir;
        if (length > 8'd1 && dir == (cur_dir ^ 2'b10))
            dir_sel = cur_dir;

        hx = head[7:4];
        hy = head[3:0];
        case (dir_eff)
            2'b00:   hy = hy - 4'd1;
            2'b01:   hx = hx + 4'd1;
            2'b10:   hy = hy + 4'd1;
            default: hx = hx - 4'd1;
        endcase
        next_cell = {hx, hy};

        // Moving into the cell the tail is about to vacate is legal.
        hit = occ[next_cell] && !(!grow_eff && next_cell == ram_rd_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            head        <= 8'h88;
            new_head    <= '0;
            tail_xy     <= '0;
            head_ptr    <= '0;
            tail_ptr    <= '0;
            length      <= 8'd1;
            cur_dir     <= 2'b01;
            dir_eff     <= 2'b01;
            grow_eff    <= 1'b0;
            occ         <= '0;
            collision   <= 1'b0;
            waitrequest <= 1'b1;
            ram_we      <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            ram_rd_addr <= '0;
            game_plot   <= 1'b0;
            game_x      <= '0;
            game_y      <= '0;
            game_colour <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                INIT: begin
                    ram_we      <= 1'b1;
                    ram_wr_addr <= '0;
                    ram_wr_data <= 8'h88;
                    occ[8'h88]  <= 1'b1;
                    state       <= DRAW;
                end
                IDLE: begin
                    if (step) begin
                        dir_eff     <= dir_sel;
                        grow_eff    <= grow && (length != 8'd255);
                        ram_rd_addr <= tail_ptr;
                        waitrequest <= 1'b1;
                        state       <= RD_TAIL;
                    end
                end
                RD_TAIL: state <= CHECK;
                CHECK: begin
                    tail_xy  <= ram_rd_data;
                    new_head <= next_cell;
                    if (hit) begin
                        collision <= 1'b1;
                        state     <= DEAD;
                    end else if (!grow_eff) begin
                        occ[ram_rd_data] <= 1'b0;
                        tail_ptr         <= tail_ptr + 8'd1;
                        if (ram_rd_data == next_cell) begin
                            state <= WRITE;
                        end else begin
                            game_plot   <= 1'b1;
                            game_x      <= ram_rd_data[7:4];
                            game_y      <= ram_rd_data[3:0];
                            game_colour <= 3'b000;
                            state       <= ERASE;
                        end
                    end else begin
                        length <= length + 8'd1;
                        state  <= WRITE;
                    end
                end
                ERASE: begin
                    if (!plot_waitrequest) begin
                        game_plot <= 1'b0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    ram_we        <= 1'b1;
                    ram_wr_addr   <= head_ptr + 8'd1;
                    ram_wr_data   <= new_head;
                    head_ptr      <= head_ptr + 8'd1;
                    occ[new_head] <= 1'b1;
                    head          <= new_head;
                    cur_dir       <= dir_eff;
                    state         <= DRAW;
                end
                DRAW: begin
                    // First DRAW cycle carries the registered RAM write; plot follows.
                    if (!game_plot) begin
                        game_plot   <= 1'b1;
                        game_x      <= head[7:4];
                        game_y      <= head[3:0];
                        game_colour <= 3'b010;
                    end else if (!plot_waitrequest) begin
                        game_plot   <= 1'b0;
                        waitrequest <= 1'b0;
                        state       <= IDLE;
                    end
                end
                DEAD: begin
                    collision   <= 1'b1;
                    waitrequest <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_step.sv
// Scoreboard bench for snake_step: a reference snake model predicts RAM writes
// and plot commands, which are compared as the DUT produces them.
module tb_snake_step;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step = 1'b0;
    logic [1:0] dir = 2'b01;
    logic       grow = 1'b0;
    logic       plot_waitrequest = 1'b0;
    logic       waitrequest;
    logic       collision;
    logic [7:0] length;
    logic       ram_we;
    logic [7:0] ram_wr_addr;
    logic [7:0] ram_wr_data;
    logic [7:0] ram_rd_addr;
    logic [7:0] ram_rd_data;
    logic       game_plot;
    logic [3:0] game_x;
    logic [3:0] game_y;
    logic [2:0] game_colour;

    snake_step dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .step             (step),
        .dir              (dir),
        .grow             (grow),
        .waitrequest      (waitrequest),
        .collision        (collision),
        .length           (length),
        .ram_we           (ram_we),
        .ram_wr_addr      (ram_wr_addr),
        .ram_wr_data      (ram_wr_data),
        .ram_rd_addr      (ram_rd_addr),
        .ram_rd_data      (ram_rd_data),
        .game_plot        (game_plot),
        .game_x           (game_x),
        .game_y           (game_y),
        .game_colour      (game_colour),
        .plot_waitrequest (plot_waitrequest)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit         is_plot;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;
    ev_t exp_q[$];

    bit [255:0] m_occ;
    logic [7:0] m_body[$];
    logic [7:0] m_head;
    int         m_len;
    logic [1:0] m_cur;
    logic [7:0] m_hp;
    bit         m_dead;

    bit stall_en = 1'b0;
    bit busy_force = 1'b0;
    logic [7:0] last_wr = '0;

    initial forever begin
        @(posedge clk);
        #2;
        plot_waitrequest = busy_force ? 1'b1 : (stall_en ? ($urandom_range(0, 3) == 0) : 1'b0);
    end

    task automatic model_reset();
        m_occ = '0;
        m_occ[8'h88] = 1'b1;
        m_body.delete();
        m_body.push_back(8'h88);
        m_head = 8'h88;
        m_len = 1;
        m_cur = 2'b01;
        m_hp = 8'd0;
        m_dead = 1'b0;
        exp_q.delete();
        exp_q.push_back('{1'b0, 8'h00, 8'h88});
        exp_q.push_back('{1'b1, 8'h88, 8'h02});
    endtask

    task automatic model_step(input logic [1:0] d, input logic g);
        logic [1:0] nd;
        logic       ge;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] nh;
        logic [7:0] tl;
        nd = d;
        if (m_len > 1 && d == (m_cur ^ 2'b10)) nd = m_cur;
        ge = g && (m_len != 255);
        x = m_head[7:4];
        y = m_head[3:0];
        case (nd)
            2'b00:   y = y - 4'd1;
            2'b01:   x = x + 4'd1;
            2'b10:   y = y + 4'd1;
            default: x = x - 4'd1;
        endcase
        nh = {x, y};
        tl = m_body[0];
        if (m_occ[nh] && !(!ge && nh == tl)) begin
            m_dead = 1'b1;
            return;
        end
        if (!ge) begin
            m_occ[tl] = 1'b0;
            void'(m_body.pop_front());
            if (tl != nh) exp_q.push_back('{1'b1, tl, 8'h00});
        end else begin
            m_len++;
        end
        m_hp = m_hp + 8'd1;
        exp_q.push_back('{1'b0, m_hp, nh});
        m_occ[nh] = 1'b1;
        m_body.push_back(nh);
        m_head = nh;
        m_cur = nd;
        exp_q.push_back('{1'b1, nh, 8'h02});
    endtask

    // Output monitor: pops the scoreboard on each RAM write and accepted plot.
    initial begin
        bit          pending;
        logic [11:0] prev_vec;
        ev_t         e;
        pending = 1'b0;
        prev_vec = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (pending)
                    check("plot_hold", {game_plot, game_x, game_y, game_colour}, prev_vec);
                if (ram_we) begin
                    last_wr = ram_wr_data;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_kind", e.is_plot, 1'b0);
                        check("wr_addr", ram_wr_addr, e.a);
                        check("wr_data", ram_wr_data, e.b);
                    end
                end
                if (game_plot && !plot_waitrequest) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_plot", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("plot_kind", e.is_plot, 1'b1);
                        check("plot_xy", {game_x, game_y}, e.a);
                        check("plot_colour", game_colour, e.b);
                    end
                end
                pending = game_plot && plot_waitrequest;
                prev_vec = {game_plot, game_x, game_y, game_colour};
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (waitrequest !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", n, 0);
    endtask

    task automatic do_step(input logic [1:0] d, input logic g, input int hold);
        if (m_dead) begin
            @(negedge clk);
            step = 1'b1; dir = d; grow = g;
            repeat (2) @(negedge clk);
            step = 1'b0;
            repeat (10) @(negedge clk);
            check("dead_wait", waitrequest, 1'b1);
            check("dead_coll", collision, 1'b1);
            return;
        end
        model_step(d, g);
        @(negedge clk);
        step = 1'b1; dir = d; grow = g;
        repeat (hold) @(negedge clk);
        step = 1'b0;
        if (m_dead) begin
            repeat (20) @(negedge clk);
            check("dead_wait", waitrequest, 1'b1);
        end else begin
            wait_ready();
        end
        check("collision", collision, m_dead);
        check("length", length, m_len);
        check("events_done", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_wait", waitrequest, 1'b1);
        check("rst_coll", collision, 1'b0);
        check("rst_len", length, 8'd1);
        check("rst_plot", game_plot, 1'b0);
        check("rst_we", ram_we, 1'b0);
        check("rst_addrs", {ram_rd_addr, ram_wr_addr, ram_wr_data}, 24'h0);
        check("rst_coord", {game_x, game_y, game_colour}, 11'h0);
        rst_n = 1'b1;
        wait_ready();
        check("init_done", exp_q.size(), 0);
        check("init_len", length, 8'd1);

        // First move right with a held step: extra busy cycles must be ignored.
        do_step(2'b01, 1'b0, 3);
        check("first_wr", last_wr, 8'h98);

        stall_en = 1'b1;
        for (int i = 0; i < 6; i++) do_step(2'b01, 1'b0, 1);
        check("at_edge", last_wr, 8'hF8);
        do_step(2'b01, 1'b0, 1);
        check("wrap_head", last_wr, 8'h08);

        for (int i = 0; i < 3; i++) do_step(2'b01, 1'b1, 1);
        check("grown_len", length, 8'd4);
        do_step(2'b11, 1'b0, 1);
        check("reverse_ignored", last_wr, 8'h48);

        do_step(2'b00, 1'b0, 1);
        do_step(2'b11, 1'b0, 1);
        do_step(2'b10, 1'b0, 1);
        do_step(2'b01, 1'b0, 1);
        check("square_len", length, 8'd4);

        do_step(2'b01, 1'b0, 1);
        do_step(2'b01, 1'b0, 1);
        do_step(2'b01, 1'b1, 1);
        check("len5", length, 8'd5);
        do_step(2'b00, 1'b1, 1);
        do_step(2'b11, 1'b1, 1);
        do_step(2'b10, 1'b1, 1);
        check("square_dead", collision, 1'b1);
        do_step(2'b01, 1'b1, 1);

        // Abort a stalled erase plot with reset.
        stall_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        check("reinit_done", exp_q.size(), 0);
        busy_force = 1'b1;
        model_step(2'b01, 1'b0);
        @(negedge clk);
        step = 1'b1; dir = 2'b01; grow = 1'b0;
        @(negedge clk);
        step = 1'b0;
        repeat (6) @(negedge clk);
        check("stuck_plot", {game_plot, game_x, game_y, game_colour}, {1'b1, 4'h8, 4'h8, 3'b000});
        #2 rst_n = 1'b0;
        #1;
        check("abort_plot", game_plot, 1'b0);
        check("abort_we", ram_we, 1'b0);
        check("abort_wait", waitrequest, 1'b1);
        model_reset();
        busy_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_quiet", {ram_we, game_plot}, 2'b00);
        end
        rst_n = 1'b1;
        wait_ready();
        check("abort_reinit", exp_q.size(), 0);
        check("abort_len", length, 8'd1);
        do_step(2'b10, 1'b0, 1);
        check("after_abort", last_wr, 8'h89);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_step.md
SNAKE_STEP -- requirements
Module: snake_step

Interface
REQ-001 SHALL have ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- step  in  1  request to advance the snake one cell
- dir  in  2  requested direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
- grow  in  1  sampled with step; snake lengthens by one
- waitrequest  out  1  high while busy; a step is accepted only when step=1 and waitrequest=0
- collision  out  1  sticky self-collision flag
- length  out  8  current snake length in cells
- ram_we  out  1  body-buffer write enable
- ram_wr_addr  out  8  body-buffer write address
- ram_wr_data  out  8  cell {x[7:4],y[3:0]}
- ram_rd_addr  out  8  body-buffer read address
- ram_rd_data  in  8  read data, valid one cycle after ram_rd_addr is presented
- game_plot  out  1  cell-plot request to the downstream cell plotter
- game_x  out  4  plot cell x
- game_y  out  4  plot cell y
- game_colour  out  3  plot colour
- plot_waitrequest  in  1  downstream busy; a plot command is accepted in a cycle where game_plot=1 and plot_waitrequest=0
REQ-002 Clock is clk and reset is rst_n, asynchronous, active-low; single clock domain.

Function
REQ-003 SHALL keep the snake body as a 256-entry circular buffer in external RAM, with 8-bit head_ptr and tail_ptr.
REQ-004 SHALL hold a 256-bit occupancy map indexed by {x,y}; bit=1 means a body cell.
REQ-005 SHALL use the states INIT, IDLE, RD_TAIL, CHECK, ERASE, WRITE, DRAW and DEAD.
REQ-006 INIT (1 cycle): ram_we=1, ram_wr_addr=0, ram_wr_data=8'h88; set occ[8'h88]; go to DRAW.
REQ-007 IDLE: waitrequest=0; on step=1: latch dir_eff and grow_eff, set ram_rd_addr=tail_ptr, go to RD_TAIL.
REQ-008 dir_eff rule:
- dir_eff = dir, except keep cur_dir when dir == cur_dir^2'b10 and length>1.
- cur_dir resets to 01.
REQ-009 grow_eff = grow && (length != 255).
REQ-010 RD_TAIL: wait one cycle for RAM read latency; go to CHECK.
REQ-011 CHECK: tail_xy = ram_rd_data; new_head = head ± 1 in the dir_eff axis, modulo 16 (4-bit wrap; x=15 right gives 0, y=0 up gives 15).
REQ-012 CHECK collision condition:
- collision = occ[new_head] && !(!grow_eff && new_head==tail_xy).
- If collision: set collision=1, go to DEAD; head, pointers, length and occupancy unchanged.
REQ-013 CHECK, no collision and !grow_eff:
- clear occ[tail_xy]; tail_ptr++.
- If tail_xy==new_head, go to WRITE; otherwise go to ERASE.
REQ-014 CHECK, no collision and grow_eff: length++; go to WRITE.
REQ-015 ERASE: game_plot=1, game_x/y=tail_xy, game_colour=3'b000; hold until accepted; on acceptance drop game_plot next cycle and go to WRITE.
REQ-016 WRITE (1 cycle): ram_we=1, ram_wr_addr=head_ptr+1, ram_wr_data=new_head; head_ptr++; set occ[new_head]; head<=new_head; cur_dir<=dir_eff; go to DRAW.
REQ-017 DRAW: game_plot=1, game_x/y=head, game_colour=3'b010; hold until accepted; drop next cycle and go to IDLE.
REQ-018 Plot handshake: game_x, game_y and game_colour SHALL stay stable while game_plot=1.
REQ-019 DEAD: terminal state; waitrequest=1, collision=1, no RAM writes, no plots until reset.
REQ-020 waitrequest SHALL be 1 in every state except IDLE; step while waitrequest=1 is ignored, not queued.
REQ-021 ram_we SHALL be 1 only in INIT and WRITE.
REQ-022 Step latency with no stalls: 6 cycles from acceptance back to IDLE without ERASE; 7 with ERASE, plus any plot_waitrequest stall cycles.

Reset
REQ-023 On rst_n=0 the block SHALL immediately take the following reset values:
- state=INIT, head=8'h88, head_ptr=0, tail_ptr=0, length=1, cur_dir=01.
- occupancy cleared, collision=0, waitrequest=1, game_plot=0, ram_we=0.
- all address, data, coordinate and colour outputs=0.
REQ-024 Reset asserted mid-plot or mid-write SHALL abort the operation with no further RAM write and no further plot request.

Verification
REQ-025 Release reset -> one RAM write addr0=8'h88, then a plot of (8,8) colour 010, then IDLE with length=1.
REQ-026 step, dir=01, grow=0 -> plot of (8,8) colour 000, then write addr1=8'h98, then plot of (9,8) colour 010; length stays 1, tail_ptr=1.
REQ-027 Head at (15,8), step dir=01 -> new head (0,8) via wrap; collision=0.
REQ-028 Grow to length 4 heading right, then step dir=11 -> reversal ignored, head moves right, length=4.
REQ-029 Length 5, steps up, left, down, right (square path) with grow=1 on every step -> collision=1, no write, no plot, DEAD with waitrequest held high.
REQ-030 Length 4, square path with grow=0 on every step (new head equals the tail) -> no collision, no ERASE plot, length=4.
